// File: rtl/semaforo_pkg.sv
// Shared types for the traffic-light cycle sequencer.
// Cycle codes match the four-approach light decoder.
package semaforo_pkg;

  typedef enum logic [4:0] {
    VERDE_A   = 5'd0,
    AMBAR_A   = 5'd1,
    VERDE_B   = 5'd2,
    AMBAR_B   = 5'd3,
    VERDE_C   = 5'd4,
    AMBAR_C   = 5'd5,
    VERDE_D   = 5'd6,
    TODO_ROJO = 5'd7,
    NOCHE     = 5'd8,
    ROJO_DEST = 5'd9
  } ciclo_t;

  typedef enum logic [1:0] {
    M_NORMAL = 2'b00,
    M_NOCHE  = 2'b01,
    M_ROJO   = 2'b10,
    M_HOLD   = 2'b11
  } modo_t;

  localparam ciclo_t CICLO_RESET = TODO_ROJO;

  function automatic logic es_destello(ciclo_t c);
    return (c == NOCHE) || (c == ROJO_DEST);
  endfunction

  // Leaving a flash code always passes through all-red clearance.
  function automatic ciclo_t ciclo_sig(ciclo_t c, modo_t m);
    ciclo_t s;
    s = TODO_ROJO;
    priority case (1'b1)
      m == M_NOCHE:   s = NOCHE;
      m == M_ROJO:    s = ROJO_DEST;
      es_destello(c): s = TODO_ROJO;
      c == TODO_ROJO: s = VERDE_A;
      default:        s = ciclo_t'(c + 5'd1);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tick_1hz.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks.
// Restarts from zero on synchronous reset.
module tick_1hz #(
  parameter int TICK_DIV = 27_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] ULT = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == ULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/semaforo_secuenciador.sv
// Four-approach traffic-light cycle sequencer driving ciclo/dest.
// Green-phase flashing enabled by defining SEMAFORO_GREEN_FLASH_EN.
module semaforo_secuenciador
  import semaforo_pkg::*;
#(
  parameter int TICK_DIV = 27_000_000,
  parameter int T_GREEN  = 20,
  parameter int T_FLASH  = 3,
  parameter int T_AMBER  = 3,
  parameter int T_ALLRED = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] modo,
  output logic [4:0] ciclo,
  output logic       dest,
  output logic       fase_fin
);

`ifdef SEMAFORO_GREEN_FLASH_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  localparam logic [7:0] D_GREEN  = 8'(T_GREEN);
  localparam logic [7:0] D_FLASH  = 8'(T_FLASH);
  localparam logic [7:0] D_AMBER  = 8'(T_AMBER);
  localparam logic [7:0] D_ALLRED = 8'(T_ALLRED);

  logic       tick;
  logic [1:0] sync1;
  modo_t      modo_s;
  logic       hold;

  ciclo_t     est;
  ciclo_t     est_n;
  logic [7:0] rem;
  logic [7:0] rem_n;
  logic       dest_n;
  logic       fin_n;

  tick_1hz #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  function automatic logic [7:0] duracion(ciclo_t c);
    logic [7:0] d;
    d = D_GREEN;
    priority case (1'b1)
      es_destello(c): d = 8'd1;
      c == TODO_ROJO: d = D_ALLRED;
      c[0]:           d = D_AMBER;
      default:        d = D_GREEN;
    endcase
    return d;
  endfunction

  function automatic logic destello(ciclo_t c, logic [7:0] r);
    logic verde;
    verde = !c[0] && (c <= VERDE_D);
    return es_destello(c) || (FLASH_EN && verde && (r <= D_FLASH));
  endfunction

  assign hold  = (modo_s == M_HOLD);
  assign ciclo = est;

  always_comb begin
    est_n = est;
    rem_n = rem;
    fin_n = 1'b0;
    if (tick && !hold) begin
      if (rem == 8'd1) begin
        est_n = ciclo_sig(est, modo_s);
        rem_n = duracion(est_n);
        fin_n = 1'b1;
      end else begin
        rem_n = rem - 8'd1;
      end
    end
    dest_n = destello(est_n, rem_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 2'b00;
      modo_s   <= M_NORMAL;
      est      <= CICLO_RESET;
      rem      <= D_ALLRED;
      dest     <= 1'b0;
      fase_fin <= 1'b0;
    end else begin
      sync1    <= modo;
      modo_s   <= modo_t'(sync1);
      est      <= est_n;
      rem      <= rem_n;
      dest     <= dest_n;
      fase_fin <= fin_n;
    end
  end

endmodule

// File: doc/semaforo_secuenciador.md
# semaforo_secuenciador

Traffic-light cycle sequencer: the generating end of the 5-bit cycle-code/flash interface consumed by the four-approach light decoder. It steps through the green/amber/all-red phases of a four-approach intersection on a 1 Hz time base and drives `ciclo[4:0]` and `dest`, replacing the external controller that otherwise supplies them. The `modo` input selects night flashing, all-red flashing or a hold of the current phase.

## Interface
- `TICK_DIV`, 27_000_000 — clock cycles per 1 s tick.
- `T_GREEN`, 20 — green phase length in ticks; must be > `T_FLASH`.
- `T_FLASH`, 3 — final ticks of each green phase with `dest`=1.
- `T_AMBER`, 3 — amber phase length in ticks.
- `T_ALLRED`, 2 — all-red clearance length in ticks.
- `clk` in 1 — system clock.
- `rst` in 1 — synchronous, active-high reset.
- `modo` in 2 — mode request, asynchronous to `clk`: 00 normal, 01 night flash, 10 red flash, 11 hold.
- `ciclo` out 5 — cycle code to the decoder.
- `dest` out 1 — flash enable to the decoder.
- `fase_fin` out 1 — one-cycle pulse on every phase change.

## Operation
- Cycle codes:
  - 0 green A, 1 amber A
  - 2 green B, 3 amber B
  - 4 green C, 5 amber C
  - 6 green D, 7 all-red
  - 8 amber flash (night), 9 amber/red flash
- Normal sequence: 0→1→2→3→4→5→6→7→0.
- Phase durations in ticks:
  - even codes 0–6: `T_GREEN`
  - odd codes 1–5: `T_AMBER`
  - code 7: `T_ALLRED`
  - codes 8 and 9: 1, re-evaluated every tick
- Phase counter `rem` (8 bit) is loaded with the duration on phase entry. On each tick:
  - if `rem`==1: advance to the next phase and load the new duration;
  - otherwise: decrement.
- A phase therefore lasts exactly its duration in ticks.
- `modo` passes through a 2-flop synchronizer, then is evaluated only at phase boundaries (tick with `rem`==1):
  - 01 → code 8; 10 → code 9.
  - 00 while in code 8 or 9 → code 7 with `T_ALLRED`, then resume at 0.
  - 01 or 10 while in the other flash code → switch directly.
- `modo`=11 (hold) is the one exception to boundary-only evaluation:
  - takes effect immediately after synchronization;
  - ticks are ignored and `rem`, `ciclo`, `dest` freeze;
  - on release, counting resumes from the frozen `rem`.
- `dest` values:
  - 1 in codes 0/2/4/6 when `rem` ≤ `T_FLASH`;
  - 1 always in codes 8/9;
  - 0 in all other codes.
- Reset state: `ciclo`=7, `rem`=`T_ALLRED`, `dest`=0, `fase_fin`=0, prescaler=0, synchronizer flops=00. The intersection always starts in all-red clearance.

## Timing
- All outputs are registered and update on the clock edge where `tick` is high.
- Prescaler counts 0..`TICK_DIV`-1 and asserts `tick` for one cycle at the terminal count. First tick occurs `TICK_DIV` cycles after `rst` deasserts.
- `fase_fin` is high in the same cycle that `ciclo` first shows the new code.
- `modo` latency: 2 cycles to the synchronizer output. Hold takes effect on the next edge after that. Other modes wait for the phase boundary.
- `rst` mid-phase: next edge forces the reset state; prescaler restarts from 0.
- Simultaneous boundary and hold: hold wins; no advance, no `fase_fin`.
- Counter widths: prescaler `$clog2(TICK_DIV)`; `rem` 8 bit, so all `T_*` ≤ 255.

## Configuration
- `SEMAFORO_GREEN_FLASH_EN` defined: green phases flash for their last `T_FLASH` ticks, as above.
- Not defined: `dest`=0 in all green phases; `T_FLASH` is unused. Codes 8/9 still drive `dest`=1.

## Structure
- `semaforo_pkg` holds:
  - `typedef enum logic [4:0] ciclo_t` for codes 0–9;
  - `typedef enum logic [1:0] modo_t`;
  - constant `CICLO_RESET` = all-red.
- Sub-module `tick_1hz`: prescaler parameterized by `TICK_DIV`, producing the one-cycle `tick`.
- Top holds the synchronizer, the FSM (state = `ciclo_t`) and `rem`.

## Test plan
All scenarios use `TICK_DIV`=4, `T_GREEN`=5, `T_FLASH`=2, `T_AMBER`=2, `T_ALLRED`=1.
- Reset, `modo`=00 → `ciclo`=7, `dest`=0 until the first tick (cycle 4); then `ciclo`=0 with a `fase_fin` pulse.
- Full normal cycle → codes 0..7 with durations 20/8/20/8/20/8/20/4 cycles; `dest`=1 for the last 8 cycles of each green.
- `modo`=01 mid green B → code 8 at the B boundary, `dest`=1. `modo`=00 → code 7 for 4 cycles, then code 0.
- `modo`=11 mid amber A for 40 cycles → `ciclo`=1 and `rem` frozen; after release, the remaining amber ticks complete.
- `rst` pulsed for one cycle during code 4 → next edge `ciclo`=7, `dest`=0; the sequence restarts as in the first scenario.
- `SEMAFORO_GREEN_FLASH_EN` undefined → `dest` stays 0 through codes 0–7; code 9 still gives `dest`=1.
